// File: rtl/pixel_readout_buffer.sv
// Buffers 16-bit pixel-pair words in a small FWFT FIFO and serializes them
// into an 8-bit valid/ready pixel stream with frame first/last markers.
module pixel_readout_buffer #(
    parameter int DEPTH       = 8,
    parameter int FRAME_WORDS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              inWord,
    input  logic                     inValid,
    input  logic                     frameStart,
    output logic [7:0]               outPixel,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outFirst,
    output logic                     outLast,
    output logic                     overflow,
    input  logic                     clrOverflow,
    output logic [15:0]              frameCount,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_phase;
    logic [IW-1:0] r_word_idx;
    logic          r_overflow;
    logic [15:0]   r_frame_count;

    logic          w_full;
    logic          w_push;
    logic          w_valid;
    logic          w_hs;
    logic          w_pop;
    logic [17:0]   w_head;
    logic [IW-1:0] w_cur_idx;
    logic [IW-1:0] w_next_idx;
    logic          w_first_tag;
    logic          w_last_tag;
    logic          w_out_first;
    logic          w_out_last;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign w_push      = inValid && !w_full;
    assign w_valid     = (r_level != '0);
    assign w_hs        = w_valid && outReady;
    assign w_pop       = w_hs && r_phase;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_cur_idx   = frameStart ? '0 : r_word_idx;
    assign w_first_tag = (w_cur_idx == '0);
    assign w_last_tag  = (w_cur_idx == IW'(FRAME_WORDS - 1));
    assign w_next_idx  = w_last_tag ? '0 : w_cur_idx + 1'b1;

    assign w_out_first = w_valid && w_head[17] && !r_phase;
    assign w_out_last  = w_valid && w_head[16] && r_phase;

    assign outValid    = w_valid;
    assign outPixel    = w_valid ? (r_phase ? w_head[7:0] : w_head[15:8]) : 8'h00;
    assign outFirst    = w_out_first;
    assign outLast     = w_out_last;
    assign overflow    = r_overflow;
    assign frameCount  = r_frame_count;
    assign level       = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_first_tag, w_last_tag, inWord};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_phase       <= 1'b0;
            r_word_idx    <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= 16'h0000;
        end else begin
            // Dropped words still advance the index so frame tags stay aligned.
            if (inValid) begin
                r_word_idx <= w_next_idx;
            end else if (frameStart) begin
                r_word_idx <= '0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (w_hs) begin
                r_phase <= ~r_phase;
            end

            if (inValid && w_full) begin
                r_overflow <= 1'b1;
            end else if (clrOverflow) begin
                r_overflow <= 1'b0;
            end

            if (w_hs && w_out_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Scoreboard bench for pixel_readout_buffer: expected pixels are queued as
// words are driven and compared on every output handshake.
module tb_pixel_readout_buffer;

    localparam int DEPTH       = 8;
    localparam int FRAME_WORDS = 2;

    typedef struct {
        logic       first;
        logic       last;
        logic [7:0] pix;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] inWord;
    logic        inValid;
    logic        frameStart;
    logic [7:0]  outPixel;
    logic        outValid;
    logic        outReady;
    logic        outFirst;
    logic        outLast;
    logic        overflow;
    logic        clrOverflow;
    logic [15:0] frameCount;
    logic [3:0]  level;

    int          checks;
    int          failures;
    int          tb_idx;
    logic [15:0] exp_frames;
    exp_t        q[$];

    pixel_readout_buffer #(.DEPTH(DEPTH), .FRAME_WORDS(FRAME_WORDS)) dut (
        .clk(clk), .reset(reset), .inWord(inWord), .inValid(inValid),
        .frameStart(frameStart), .outPixel(outPixel), .outValid(outValid),
        .outReady(outReady), .outFirst(outFirst), .outLast(outLast),
        .overflow(overflow), .clrOverflow(clrOverflow),
        .frameCount(frameCount), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: each handshake pops one expected pixel.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && outValid && outReady) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL handshake_unexpected: got pix=%02h first=%0b last=%0b, expected none",
                         outPixel, outFirst, outLast);
            end else begin
                e = q.pop_front();
                if (outPixel !== e.pix || outFirst !== e.first || outLast !== e.last) begin
                    failures++;
                    $display("FAIL handshake_pixel: got pix=%02h first=%0b last=%0b, expected pix=%02h first=%0b last=%0b",
                             outPixel, outFirst, outLast, e.pix, e.first, e.last);
                end else begin
                    $display("pixel %02h first=%0b last=%0b ok", outPixel, outFirst, outLast);
                end
                if (e.last) exp_frames = exp_frames + 16'd1;
            end
        end
    end

    // Drives one word for one cycle and queues its expected pixels when accepted.
    task automatic drive_word(input logic [15:0] w, input logic fs, input logic accept);
        int   cur;
        exp_t hi;
        exp_t lo;
        cur = fs ? 0 : tb_idx;
        hi.pix = w[15:8]; hi.first = (cur == 0); hi.last = 1'b0;
        lo.pix = w[7:0];  lo.first = 1'b0;       lo.last = (cur == FRAME_WORDS - 1);
        if (accept) begin
            q.push_back(hi);
            q.push_back(lo);
        end
        tb_idx = (cur == FRAME_WORDS - 1) ? 0 : cur + 1;
        inWord = w; inValid = 1'b1; frameStart = fs;
        @(posedge clk); #1;
        inValid = 1'b0; frameStart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inWord = '0; inValid = 0; frameStart = 0;
        outReady = 0; clrOverflow = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({outPixel, outValid, outFirst, outLast, overflow} !== 12'h000 ||
            frameCount !== 16'h0 || level !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got pix=%02h v=%0b f=%0b l=%0b ovf=%0b fc=%0d lvl=%0d, expected all 0",
                     outPixel, outValid, outFirst, outLast, overflow, frameCount, level);
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 400 && q.size() != 0; c++) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain_timeout: got %0d pixels pending, expected 0", name, q.size());
        end
        checks++;
        if (level !== 4'd0 || outValid !== 1'b0) begin
            failures++;
            $display("FAIL %s_level_empty: got level=%0d valid=%0b, expected 0 0", name, level, outValid);
        end
    endtask

    task automatic test_single_word();
        outReady = 1'b1;
        drive_word(16'hA55A, 1'b1, 1'b1);
        checks++;
        if (outValid !== 1'b1 || outPixel !== 8'hA5 || outFirst !== 1'b1 || level !== 4'd1) begin
            failures++;
            $display("FAIL single_latency: got v=%0b pix=%02h first=%0b lvl=%0d, expected 1 a5 1 1",
                     outValid, outPixel, outFirst, level);
        end
        drain("single");
    endtask

    task automatic test_full_frame();
        outReady = 1'b1;
        drive_word(16'h0102, 1'b1, 1'b1);
        drive_word(16'h0304, 1'b0, 1'b1);
        drain("frame");
        checks++;
        if (frameCount !== exp_frames || exp_frames !== 16'd1) begin
            failures++;
            $display("FAIL frame_count: got %0d, expected %0d (model %0d)", frameCount, 16'd1, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        drive_word(16'h1234, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (outPixel !== 8'h12 || outFirst !== 1'b1 || outValid !== 1'b1 || level !== 4'd1) begin
                failures++;
                $display("FAIL backpressure_hold: got pix=%02h first=%0b v=%0b lvl=%0d, expected 12 1 1 1",
                         outPixel, outFirst, outValid, level);
            end
        end
        outReady = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_overflow();
        outReady = 1'b0;
        for (int i = 0; i < 9; i++) drive_word(16'h1000 + 16'(i * 16'h0101), (i == 0), (i < 8));
        checks++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got level=%0d ovf=%0b, expected 8 1", level, overflow);
        end
        clrOverflow = 1'b1; @(posedge clk); #1; clrOverflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: got %0b, expected 0", overflow);
        end
        clrOverflow = 1'b1;
        drive_word(16'hDEAD, 1'b0, 1'b0);
        clrOverflow = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL overflow_set_wins: got ovf=%0b lvl=%0d, expected 1 8", overflow, level);
        end
        clrOverflow = 1'b1; @(posedge clk); #1; clrOverflow = 1'b0;
        outReady = 1'b1;
        drain("overflow");
        drive_word(16'h5566, 1'b1, 1'b1);
        drive_word(16'h7788, 1'b0, 1'b1);
        drain("overflow_next");
        checks++;
        if (frameCount !== exp_frames || overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_frames: got fc=%0d ovf=%0b, expected fc=%0d ovf=0",
                     frameCount, overflow, exp_frames);
        end
    endtask

    task automatic test_reset_midstream();
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) drive_word(16'hC0C1 + 16'(i), (i == 0), 1'b1);
        outReady = 1'b1; @(posedge clk); #1; outReady = 1'b0;
        checks++;
        if (level !== 4'd5 || outPixel !== 8'hC1) begin
            failures++;
            $display("FAIL midstream_setup: got level=%0d pix=%02h, expected 5 c1", level, outPixel);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({outPixel, outValid, outFirst, outLast, overflow} !== 12'h000 ||
            frameCount !== 16'h0 || level !== 4'd0) begin
            failures++;
            $display("FAIL midstream_reset: got pix=%02h v=%0b f=%0b l=%0b fc=%0d lvl=%0d, expected all 0",
                     outPixel, outValid, outFirst, outLast, frameCount, level);
        end
        q.delete(); tb_idx = 0; exp_frames = 16'h0;
        @(posedge clk); #1 reset = 1'b0;
        outReady = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("FAIL midstream_empty: got valid=%0b, expected 0", outValid);
        end
        drive_word(16'hBEEF, 1'b1, 1'b1);
        checks++;
        if (outPixel !== 8'hBE || outFirst !== 1'b1) begin
            failures++;
            $display("FAIL midstream_high_first: got pix=%02h first=%0b, expected be 1", outPixel, outFirst);
        end
        drain("midstream");
    endtask

    task automatic test_frame_count_wrap();
        @(posedge clk); #1;
        force dut.r_frame_count = 16'hFFFF;
        #1 release dut.r_frame_count;
        exp_frames = 16'hFFFF;
        checks++;
        if (frameCount !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %04h, expected ffff", frameCount);
        end
        outReady = 1'b1;
        drive_word(16'h0A0B, 1'b1, 1'b1);
        drive_word(16'h0C0D, 1'b0, 1'b1);
        drain("wrap");
        checks++;
        if (frameCount !== 16'h0000 || exp_frames !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_count: got %04h, expected 0000 (model %04h)", frameCount, exp_frames);
        end
    endtask

    initial begin
        checks = 0; failures = 0; tb_idx = 0; exp_frames = 16'h0;
        test_reset();
        test_single_word();
        test_full_frame();
        test_backpressure();
        test_overflow();
        test_reset_midstream();
        test_frame_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
